// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes opcode/funct into ALU op and operands (S1), drives the external
// combinational ALU, and registers its result into a writeback handshake (S2).
module alu_issue_stage #(
    parameter int          IMM_W      = 16,
    parameter int          RA_W       = 5,
    parameter logic [2:0]  ILLEGAL_OP = 3'b111
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       in_opcode,
    input  logic [5:0]       in_funct,
    input  logic [31:0]      in_rs_val,
    input  logic [31:0]      in_rt_val,
    input  logic [IMM_W-1:0] in_imm,
    input  logic [RA_W-1:0]  in_rd,
    output logic [31:0]      alu_num1,
    output logic [31:0]      alu_num2,
    output logic [2:0]       alu_op,
    input  logic [31:0]      alu_result,
    input  logic             alu_zero,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic             out_zero,
    output logic [RA_W-1:0]  out_rd,
    output logic             out_wen,
    output logic             out_branch,
    output logic             out_illegal
);

    logic [2:0]      dec_op;
    logic [31:0]     dec_num2;
    logic            dec_wen;
    logic            dec_branch;
    logic            dec_illegal;
    logic [31:0]     imm_sext;
    logic [31:0]     imm_zext;

    logic            s1_valid;
    logic [RA_W-1:0] s1_rd;
    logic            s1_wen;
    logic            s1_branch;
    logic            s1_illegal;

    logic            s2_free;
    logic            accept;

    assign imm_sext = {{(32-IMM_W){in_imm[IMM_W-1]}}, in_imm};
    assign imm_zext = {{(32-IMM_W){1'b0}}, in_imm};

    assign s2_free  = !out_valid || out_ready;
    // Ready never looks at in_valid, so upstream can use it without a combinational loop.
    assign in_ready = !flush && (!s1_valid || s2_free);
    assign accept   = in_valid && in_ready;

    always_comb begin
        dec_op      = ILLEGAL_OP;
        dec_num2    = 32'd0;
        dec_wen     = 1'b0;
        dec_branch  = 1'b0;
        dec_illegal = 1'b1;
        case (in_opcode)
            6'b000000: begin
                dec_num2    = in_rt_val;
                dec_wen     = 1'b1;
                dec_illegal = 1'b0;
                case (in_funct)
                    6'b100000: dec_op = 3'b000;
                    6'b100010: dec_op = 3'b001;
                    6'b100100: dec_op = 3'b010;
                    6'b100101: dec_op = 3'b011;
                    6'b100111: dec_op = 3'b100;
                    6'b101010: dec_op = 3'b101;
                    default: begin
                        dec_op      = ILLEGAL_OP;
                        dec_num2    = 32'd0;
                        dec_wen     = 1'b0;
                        dec_illegal = 1'b1;
                    end
                endcase
            end
            6'b001000: begin
                dec_op      = 3'b000;
                dec_num2    = imm_sext;
                dec_wen     = 1'b1;
                dec_illegal = 1'b0;
            end
            6'b001100: begin
                dec_op      = 3'b010;
                dec_num2    = imm_zext;
                dec_wen     = 1'b1;
                dec_illegal = 1'b0;
            end
            6'b001101: begin
                dec_op      = 3'b011;
                dec_num2    = imm_zext;
                dec_wen     = 1'b1;
                dec_illegal = 1'b0;
            end
            6'b001010: begin
                dec_op      = 3'b101;
                dec_num2    = imm_sext;
                dec_wen     = 1'b1;
                dec_illegal = 1'b0;
            end
            6'b000100: begin
                dec_op      = 3'b001;
                dec_num2    = in_rt_val;
                dec_branch  = 1'b1;
                dec_illegal = 1'b0;
            end
            default: ;
        endcase
    end

    // S1: the ALU operand registers hold steady while S2 is blocked.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            alu_op     <= 3'b000;
            alu_num1   <= 32'd0;
            alu_num2   <= 32'd0;
            s1_rd      <= '0;
            s1_wen     <= 1'b0;
            s1_branch  <= 1'b0;
            s1_illegal <= 1'b0;
        end else if (flush) begin
            s1_valid <= 1'b0;
        end else if (accept) begin
            s1_valid   <= 1'b1;
            alu_op     <= dec_op;
            alu_num1   <= in_rs_val;
            alu_num2   <= dec_num2;
            s1_rd      <= in_rd;
            s1_wen     <= dec_wen;
            s1_branch  <= dec_branch;
            s1_illegal <= dec_illegal;
        end else if (s2_free) begin
            s1_valid <= 1'b0;
        end
    end

    // S2: captures the ALU's same-cycle result whenever the writeback slot is free.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_result  <= 32'd0;
            out_zero    <= 1'b0;
            out_rd      <= '0;
            out_wen     <= 1'b0;
            out_branch  <= 1'b0;
            out_illegal <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (s2_free) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_result  <= alu_result;
                out_zero    <= alu_zero;
                out_rd      <= s1_rd;
                out_wen     <= s1_wen;
                out_branch  <= s1_branch && alu_zero;
                out_illegal <= s1_illegal;
            end
        end
    end

endmodule
